// File: rtl/i2c_sram_target_pkg.sv
// Shared types and constants for the I2C SRAM target.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    DEV_ACK,
    WADDR,
    WA_ACK,
    WR,
    WR_ACK,
    RD,
    RD_ACK
  } i2c_tgt_state_t;

  localparam logic RW_READ     = 1'b1;
  localparam int   SYNC_STAGES = 2;

endpackage

// File: rtl/i2c_sram_target_bus_sync.sv
// SCL/SDA synchronizers plus registered edge and START/STOP detection.
// All outputs are registered and mutually aligned, so sda_s is the SDA
// level that belongs to the scl_rise/scl_fall pulse of the same cycle.
module i2c_bus_sync
  import i2c_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sh;
  logic [SYNC_STAGES-1:0] sda_sh;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_now;
  logic                   sda_now;

  assign scl_now = scl_sh[SYNC_STAGES-1];
  assign sda_now = sda_sh[SYNC_STAGES-1];

  // Synchronize both pins, keep the previous level, and register edge events.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scl_sh    <= '1;
      sda_sh    <= '1;
      scl_d     <= 1'b1;
      sda_d     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_s     <= 1'b1;
    end else begin
      scl_sh    <= {scl_sh[SYNC_STAGES-2:0], scl_in};
      sda_sh    <= {sda_sh[SYNC_STAGES-2:0], sda_in};
      scl_d     <= scl_now;
      sda_d     <= sda_now;
      scl_rise  <= scl_now & ~scl_d;
      scl_fall  <= ~scl_now & scl_d;
      start_det <= scl_now & scl_d & sda_d & ~sda_now;
      stop_det  <= scl_now & scl_d & ~sda_d & sda_now;
      sda_s     <= sda_now;
    end
  end

endmodule

// File: rtl/i2c_sram_target.sv
// I2C target backed by an internal byte SRAM with auto-incrementing pointer.
// Optional write protect input enabled by I2C_SRAM_WRITE_PROTECT_EN.
module i2c_sram_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         DEPTH    = 256,
  parameter int         AW       = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          scl_in,
  input  logic          sda_in,
`ifdef I2C_SRAM_WRITE_PROTECT_EN
  input  logic          wp,
`endif
  output logic          sda_oe,
  output logic          busy,
  output logic [AW-1:0] ptr
);

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_s;

  i2c_bus_sync u_bus_sync (
    .clock     (clock),
    .reset_n   (reset_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  logic wp_eff;
`ifdef I2C_SRAM_WRITE_PROTECT_EN
  assign wp_eff = wp;
`else
  assign wp_eff = 1'b0;
`endif

  i2c_tgt_state_t state, state_nx;
  logic [2:0]     bit_cnt, cnt_nx;
  logic [7:0]     shreg, sh_nx;
  logic           oe_nx;
  logic [AW-1:0]  ptr_nx;
  logic [AW-1:0]  ptr_inc;
  logic           rw_q, rw_nx;
  logic           nack_q, nack_nx;
  logic           mem_we;
  logic [7:0]     shift_in;
  logic [7:0]     rd_byte;
  logic [7:0]     rd_next;

  logic [7:0] mem [DEPTH];

  assign ptr_inc  = ptr + 1'b1;
  assign shift_in = {shreg[6:0], sda_s};
  assign rd_byte  = mem[ptr];
  assign rd_next  = mem[ptr_inc];
  assign busy     = (state != IDLE);

  // State, shift register, pointer and SDA driver registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      sda_oe  <= 1'b0;
      ptr     <= '0;
      rw_q    <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_cnt <= cnt_nx;
      shreg   <= sh_nx;
      sda_oe  <= oe_nx;
      ptr     <= ptr_nx;
      rw_q    <= rw_nx;
      nack_q  <= nack_nx;
    end
  end

  // Memory write port; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem[ptr] <= shift_in;
  end

  // Next-state and datapath decode. In ACK states bit_cnt acts as a phase
  // flag: 0 = before the ACK clock's rising edge, 1 = after it.
  // Entering RD from DEV_ACK drives the first data bit on the same SCL fall
  // that ends the ACK slot, so there is no separate release there.
  always_comb begin
    state_nx = state;
    cnt_nx   = bit_cnt;
    sh_nx    = shreg;
    oe_nx    = sda_oe;
    ptr_nx   = ptr;
    rw_nx    = rw_q;
    nack_nx  = nack_q;
    mem_we   = 1'b0;

    if (start_det) begin
      state_nx = DEV;
      cnt_nx   = '0;
      oe_nx    = 1'b0;
    end else if (stop_det) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      oe_nx    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          oe_nx  = 1'b0;
          cnt_nx = '0;
        end

        DEV: if (scl_rise) begin
          sh_nx  = shift_in;
          cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (shift_in[7:1] == DEV_ADDR) begin
              state_nx = DEV_ACK;
              rw_nx    = shift_in[0];
              nack_nx  = 1'b0;
            end else begin
              state_nx = IDLE;
            end
          end
        end

        WADDR: if (scl_rise) begin
          sh_nx  = shift_in;
          cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            ptr_nx   = shift_in[AW-1:0];
            nack_nx  = 1'b0;
            state_nx = WA_ACK;
          end
        end

        WR: if (scl_rise) begin
          sh_nx  = shift_in;
          cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (wp_eff) begin
              nack_nx = 1'b1;
            end else begin
              mem_we  = 1'b1;
              ptr_nx  = ptr_inc;
              nack_nx = 1'b0;
            end
            state_nx = WR_ACK;
          end
        end

        DEV_ACK, WA_ACK, WR_ACK: begin
          if (scl_rise) begin
            cnt_nx = 3'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              oe_nx = ~nack_q;
            end else begin
              oe_nx  = 1'b0;
              cnt_nx = '0;
              if (state == DEV_ACK && rw_q == RW_READ) begin
                state_nx = RD;
                sh_nx    = rd_byte;
                oe_nx    = ~rd_byte[7];
              end else if (state == DEV_ACK) begin
                state_nx = WADDR;
              end else begin
                state_nx = WR;
              end
            end
          end
        end

        RD: begin
          if (scl_fall) begin
            oe_nx = ~shreg[7];
          end else if (scl_rise) begin
            sh_nx  = {shreg[6:0], 1'b1};
            cnt_nx = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state_nx = RD_ACK;
              cnt_nx   = '0;
            end
          end
        end

        RD_ACK: begin
          if (scl_fall) begin
            oe_nx = 1'b0;
          end else if (scl_rise) begin
            cnt_nx = '0;
            if (!sda_s) begin
              ptr_nx   = ptr_inc;
              sh_nx    = rd_next;
              state_nx = RD;
            end else begin
              state_nx = IDLE;
            end
          end
        end

        default: begin
          state_nx = IDLE;
          oe_nx    = 1'b0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_sram_target.sv
// Directed bench for i2c_sram_target: bus-level master with open-drain SDA.
module tb_i2c_sram_target;

  localparam int Q = 100;  // quarter SCL period in ns (clock period 10 ns)

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_m   = 1'b1;
  logic       sda_m   = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic       busy;
  logic [7:0] ptr;
`ifdef I2C_SRAM_WRITE_PROTECT_EN
  logic       wp = 1'b0;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  logic oe_seen = 1'b0;
  logic ack;
  logic [7:0] rd;

  always #5 clock = ~clock;

  assign sda_line = sda_m & ~sda_oe;

  always @(posedge sda_oe) oe_seen = 1'b1;

  i2c_sram_target #(.DEV_ADDR(7'h50), .DEPTH(256)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .scl_in  (scl_m),
    .sda_in  (sda_line),
`ifdef I2C_SRAM_WRITE_PROTECT_EN
    .wp      (wp),
`endif
    .sda_oe  (sda_oe),
    .busy    (busy),
    .ptr     (ptr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_cond();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    a = ~sda_line; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    sda_m = 1'b1;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      #Q; scl_m = 1'b1;
      #Q; d = {d[6:0], sda_line};
      #Q; scl_m = 1'b0;
      #Q;
    end
    send_bit(nack);
    sda_m = 1'b1;
  endtask

  initial begin
    #23;
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ptr", ptr, 8'h00);
    reset_n = 1'b1;
    #(2*Q);

    // preload mem[0x11] = 0x5A
    start_cond();
    write_byte(8'hA0, ack); check("pre_dev_ack", ack, 1'b1);
    write_byte(8'h11, ack); check("pre_addr_ack", ack, 1'b1);
    write_byte(8'h5A, ack); check("pre_data_ack", ack, 1'b1);
    stop_cond();
    check("pre_mem11", dut.mem[8'h11], 8'h5A);

    // single byte write 0x3C to 0x10
    start_cond();
    write_byte(8'hA0, ack); check("w1_dev_ack", ack, 1'b1);
    check("w1_busy", busy, 1'b1);
    write_byte(8'h10, ack); check("w1_addr_ack", ack, 1'b1);
    write_byte(8'h3C, ack); check("w1_data_ack", ack, 1'b1);
    stop_cond();
    #Q;
    check("w1_mem10", dut.mem[8'h10], 8'h3C);
    check("w1_ptr", ptr, 8'h11);
    check("w1_busy_stop", busy, 1'b0);

    // random read of two bytes via repeated START
    start_cond();
    write_byte(8'hA0, ack);
    write_byte(8'h10, ack);
    start_cond();
    write_byte(8'hA1, ack); check("r1_dev_ack", ack, 1'b1);
    read_byte(1'b0, rd); check("r1_byte0", rd, 8'h3C);
    check("r1_ptr_mid", ptr, 8'h11);
    read_byte(1'b1, rd); check("r1_byte1", rd, 8'h5A);
    check("r1_oe_nack", sda_oe, 1'b0);
    stop_cond();
    #Q;
    check("r1_busy_stop", busy, 1'b0);
    check("r1_ptr", ptr, 8'h11);

    // wrong device address is ignored
    oe_seen = 1'b0;
    start_cond();
    write_byte(8'hA2, ack); check("na_dev_ack", ack, 1'b0);
    check("na_busy", busy, 1'b0);
    write_byte(8'h10, ack);
    write_byte(8'h77, ack);
    stop_cond();
    check("na_oe_seen", oe_seen, 1'b0);
    check("na_mem10", dut.mem[8'h10], 8'h3C);
    check("na_ptr", ptr, 8'h11);

    // pointer wrap on write
    start_cond();
    write_byte(8'hA0, ack);
    write_byte(8'hFF, ack);
    write_byte(8'h11, ack); check("wr_ack0", ack, 1'b1);
    write_byte(8'h22, ack); check("wr_ack1", ack, 1'b1);
    stop_cond();
    check("wr_memff", dut.mem[8'hFF], 8'h11);
    check("wr_mem00", dut.mem[8'h00], 8'h22);
    check("wr_ptr", ptr, 8'h01);

    // pointer wrap on read
    start_cond();
    write_byte(8'hA0, ack);
    write_byte(8'hFF, ack);
    start_cond();
    write_byte(8'hA1, ack);
    read_byte(1'b0, rd); check("rw_byte0", rd, 8'h11);
    read_byte(1'b1, rd); check("rw_byte1", rd, 8'h22);
    stop_cond();
    check("rw_ptr", ptr, 8'h00);

    // STOP after a partial data byte
    start_cond();
    write_byte(8'hA0, ack);
    write_byte(8'h10, ack);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    stop_cond();
    #Q;
    check("pb_mem10", dut.mem[8'h10], 8'h3C);
    check("pb_ptr", ptr, 8'h10);
    check("pb_busy", busy, 1'b0);

    // reset during a read releases SDA at once
    start_cond();
    write_byte(8'hA0, ack);
    write_byte(8'h10, ack);
    start_cond();
    write_byte(8'hA1, ack);
    check("mr_oe_before", sda_oe, 1'b1);
    check("mr_ptr_before", ptr, 8'h10);
    #2 reset_n = 1'b0;
    #2;
    check("mr_oe_reset", sda_oe, 1'b0);
    check("mr_ptr_reset", ptr, 8'h00);
    check("mr_busy_reset", busy, 1'b0);
    check("mr_mem10", dut.mem[8'h10], 8'h3C);
    #20 reset_n = 1'b1;
    #Q;
    stop_cond();

    // current-address read from pointer 0 after reset
    start_cond();
    write_byte(8'hA1, ack); check("ca_dev_ack", ack, 1'b1);
    read_byte(1'b1, rd); check("ca_byte", rd, 8'h22);
    stop_cond();

`ifdef I2C_SRAM_WRITE_PROTECT_EN
    start_cond();
    write_byte(8'hA0, ack);
    write_byte(8'h20, ack);
    write_byte(8'h00, ack);
    stop_cond();
    wp = 1'b1;
    start_cond();
    write_byte(8'hA0, ack); check("wp_dev_ack", ack, 1'b1);
    write_byte(8'h20, ack); check("wp_addr_ack", ack, 1'b1);
    write_byte(8'h55, ack); check("wp_data_nack", ack, 1'b0);
    stop_cond();
    check("wp_mem20", dut.mem[8'h20], 8'h00);
    check("wp_ptr", ptr, 8'h20);
    wp = 1'b0;
`endif

    #Q;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
